// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, 32-bit, signed and unsigned.
// Produces {quotient, remainder} 35 cycles after operand acceptance.
// Optional feature: define DIV_FLUSH_EN to add the flush abort port.
module iter_divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
`ifdef DIV_FLUSH_EN
  input  logic        flush,
`endif
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [63:0] dout,
  output logic        busy
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_POST, S_DONE} state_t;

  state_t state, state_nxt;
  logic   abort;

  logic [4:0] cnt;

  // Operand registers as accepted; kept intact so a zero divisor can return
  // the original dividend as the remainder.
  logic signed [DATA_W-1:0] opa;
  logic signed [DATA_W-1:0] opb;
  logic                     sgn;

  // qr starts as |dividend| and is shifted left each iteration, its vacated
  // LSBs collecting quotient bits, so after 32 steps it holds |quotient|.
  logic [DATA_W-1:0] qr;
  logic [DATA_W-1:0] dvs_mag;
  logic [DATA_W:0]   rem;
  logic              q_neg;
  logic              r_neg;

  logic [DATA_W:0]          shifted;
  logic signed [DATA_W+1:0] trial;
  logic [DATA_W-1:0]        q_res;
  logic [DATA_W-1:0]        r_res;

`ifdef DIV_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  // Magnitude of a two's complement value; 0x80000000 maps to itself, which
  // is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic                     en);
    if (en && v[DATA_W-1]) mag = unsigned'(-v);
    else                   mag = unsigned'(v);
  endfunction

  // Conditional two's complement negation used to restore result signs.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] m,
                                                   input logic              neg);
    if (neg) apply_sign = (~m) + DATA_W'(1);
    else     apply_sign = m;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and handshake outputs; abort overrides every state.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_PREP;
      end
      S_PREP: state_nxt = S_ITER;
      S_ITER: if (cnt == 5'd31) state_nxt = S_POST;
      S_POST: state_nxt = S_DONE;
      S_DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {rem[DATA_W-1:0], qr[DATA_W-1]};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, dvs_mag});
  end

  // Sign fix-up; a zero divisor bypasses it and forces all-ones / dividend.
  always_comb begin
    if (opb == '0) begin
      q_res = '1;
      r_res = unsigned'(opa);
    end else begin
      q_res = apply_sign(qr, q_neg);
      r_res = apply_sign(rem[DATA_W-1:0], r_neg && (rem != '0));
    end
  end

  // Iteration counter and result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      dout <= '0;
    end else begin
      if (state == S_PREP)      cnt <= '0;
      else if (state == S_ITER) cnt <= cnt + 5'd1;
      if (state == S_POST && !abort) dout <= {q_res, r_res};
    end
  end

  // Datapath registers: operand capture, magnitude prep, restoring iteration.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          opa <= dividend;
          opb <= divisor;
          sgn <= in_signed;
        end
      end
      S_PREP: begin
        qr      <= mag(opa, sgn);
        dvs_mag <= mag(opb, sgn);
        q_neg   <= sgn & (opa[DATA_W-1] ^ opb[DATA_W-1]);
        r_neg   <= sgn & opa[DATA_W-1];
        rem     <= '0;
      end
      S_ITER: begin
        qr  <= {qr[DATA_W-2:0], ~trial[DATA_W+1]};
        rem <= trial[DATA_W+1] ? shifted : unsigned'(trial[DATA_W:0]);
      end
      default: ;
    endcase
  end

endmodule
